// File: rtl/pie_tx_gen.sv
// pie_tx_gen: PIE line encoder with a byte-wide frame buffer, delimiter, preamble/frame-sync and data symbols.
// Define PIE_TX_CRC_EN to compile in CRC5/CRC16 generation and the CRC state; otherwise crc_sel is ignored.
module pie_tx_gen #(
  parameter int MAX_BITS = 512,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_stb,
  input  logic [7:0]       wr_data,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             preamble_sel,
  input  logic [1:0]       crc_sel,
  input  logic [CNT_W-1:0] tari,
  input  logic [CNT_W-1:0] rtcal,
  input  logic [CNT_W-1:0] trcal,
  input  logic [CNT_W-1:0] delim,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int          MAX_BYTES  = MAX_BITS / 8;
  localparam int          AW         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [AW:0] FULL       = (AW+1)'(MAX_BYTES);
  localparam logic [31:0] MAX_BITS_W = 32'(MAX_BITS);

  typedef enum logic [2:0] {
    IDLE,
    DELIM,
    SYNC,
    DATA,
    CRC,
    FINISH
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [2:0]       phase;
  logic [2:0]       next_phase;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] seg_len;
  logic             seg_end;
  logic             sym_end;
  logic             line;
  logic             cur_bit;

  logic [CNT_W-1:0] bit_idx;
  logic [AW:0]      wr_ptr;
  logic [7:0]       mem [MAX_BYTES];
  logic             buf_bit;
  logic             wr_ok;

  logic [CNT_W-1:0] tari_q;
  logic [CNT_W-1:0] rtcal_q;
  logic [CNT_W-1:0] trcal_q;
  logic [CNT_W-1:0] delim_q;
  logic [CNT_W-1:0] len_q;
  logic             pre_q;
  logic [CNT_W-1:0] tari3;

  logic             len_ok;
  logic             start_ok;

  // Zero-length segments would never reach terminal count, so clamp all latched timings to >= 1.
  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign len_ok   = (frame_len != '0) && (32'(frame_len) <= MAX_BITS_W);
  assign start_ok = (state == IDLE) && start && len_ok;
  assign wr_ok    = wr_stb && (state == IDLE) && (wr_ptr != FULL);
  assign tari3    = tari_q + {tari_q[CNT_W-2:0], 1'b0};
  assign buf_bit  = mem[bit_idx[AW+2:3]][~bit_idx[2:0]];

`ifdef PIE_TX_CRC_EN
  logic [1:0]  crc_sel_q;
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic [4:0]  crc_idx;
  logic        crc_on;
  logic        crc_bit;
  logic        crc_last;

  assign crc_on   = (crc_sel_q == 2'b01) || (crc_sel_q == 2'b10);
  // CRC5 goes out as-is; CRC16 goes out ones-complemented, both MSB first.
  assign crc_bit  = (crc_sel_q == 2'b01) ? crc5[3'd4 - crc_idx[2:0]]
                                         : ~crc16[4'd15 - crc_idx[3:0]];
  assign crc_last = (crc_sel_q == 2'b01) ? (crc_idx == 5'd4) : (crc_idx == 5'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_sel_q <= 2'b00;
      crc5      <= '0;
      crc16     <= '0;
      crc_idx   <= '0;
    end else if (start_ok) begin
      crc_sel_q <= crc_sel;
      crc5      <= 5'b01001;
      crc16     <= 16'hFFFF;
      crc_idx   <= '0;
    end else begin
      if (sym_end && (state == DATA)) begin
        crc5  <= {crc5[3:0], 1'b0}   ^ ((buf_bit ^ crc5[4])  ? 5'b01001   : 5'b00000);
        crc16 <= {crc16[14:0], 1'b0} ^ ((buf_bit ^ crc16[15]) ? 16'h1021 : 16'h0000);
      end
      if (sym_end && (state == CRC)) begin
        crc_idx <= crc_idx + 5'd1;
      end
    end
  end
`else
  logic unused_crc_sel;
  assign unused_crc_sel = ^crc_sel;
`endif

  always_comb begin
    next_state = state;
    next_phase = phase;
    seg_len    = '0;
    line       = 1'b1;
    cur_bit    = buf_bit;
`ifdef PIE_TX_CRC_EN
    if (state == CRC) cur_bit = crc_bit;
`endif

    // Segment length and line level; even phases are high, odd phases low.
    case (state)
      DELIM: begin
        line    = 1'b0;
        seg_len = delim_q;
      end
      SYNC: begin
        line = ~phase[0];
        case (phase)
          3'd2:    seg_len = rtcal_q;
          3'd4:    seg_len = trcal_q;
          default: seg_len = tari_q;
        endcase
      end
      DATA, CRC: begin
        line    = ~phase[0];
        seg_len = (!phase[0] && cur_bit) ? tari3 : tari_q;
      end
      default: ;
    endcase

    seg_end = (cnt == seg_len);
    sym_end = seg_end && phase[0] && ((state == DATA) || (state == CRC));

    case (state)
      IDLE: begin
        if (start_ok) begin
          next_state = DELIM;
          next_phase = 3'd0;
        end
      end
      DELIM: begin
        if (seg_end) begin
          next_state = SYNC;
          next_phase = 3'd0;
        end
      end
      SYNC: begin
        if (seg_end) begin
          if (phase == (pre_q ? 3'd5 : 3'd3)) begin
            next_state = DATA;
            next_phase = 3'd0;
          end else begin
            next_phase = phase + 3'd1;
          end
        end
      end
      DATA: begin
        if (seg_end) begin
          if (!phase[0]) begin
            next_phase = 3'd1;
          end else begin
            next_phase = 3'd0;
            if (bit_idx == (len_q - CNT_W'(1))) begin
`ifdef PIE_TX_CRC_EN
              next_state = crc_on ? CRC : FINISH;
`else
              next_state = FINISH;
`endif
            end
          end
        end
      end
`ifdef PIE_TX_CRC_EN
      CRC: begin
        if (seg_end) begin
          if (!phase[0]) begin
            next_phase = 3'd1;
          end else begin
            next_phase = 3'd0;
            if (crc_last) next_state = FINISH;
          end
        end
      end
`endif
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign tx   = line;
  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= 3'd0;
      cnt     <= '0;
      bit_idx <= '0;
      wr_ptr  <= '0;
      err     <= 1'b0;
      tari_q  <= '0;
      rtcal_q <= '0;
      trcal_q <= '0;
      delim_q <= '0;
      len_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state <= next_state;
      phase <= next_phase;

      // Segment counter runs 1..seg_len and restarts at 1 on each new segment.
      if (next_state == IDLE)              cnt <= '0;
      else if ((state == IDLE) || seg_end) cnt <= CNT_W'(1);
      else                                 cnt <= cnt + CNT_W'(1);

      if (start_ok) begin
        bit_idx <= '0;
        tari_q  <= nz(tari);
        rtcal_q <= nz(rtcal);
        trcal_q <= nz(trcal);
        delim_q <= nz(delim);
        len_q   <= frame_len;
        pre_q   <= preamble_sel;
      end else if (sym_end && (state == DATA)) begin
        bit_idx <= bit_idx + CNT_W'(1);
      end

      if (state == FINISH)  wr_ptr <= '0;
      else if (wr_ok)       wr_ptr <= wr_ptr + (AW+1)'(1);

      if (start_ok) err <= 1'b0;
      if ((state == IDLE) && start && !len_ok) err <= 1'b1;
      if (wr_stb && ((state != IDLE) || (wr_ptr == FULL))) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_pie_tx_gen.sv
// Bench for pie_tx_gen: waveform model built from symbol rules, per-cycle compare, and a PIE decoder.
module tb_pie_tx_gen;
  localparam int MAX_BITS = 512;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_stb;
  logic [7:0]       wr_data;
  logic             start;
  logic [CNT_W-1:0] frame_len;
  logic             preamble_sel;
  logic [1:0]       crc_sel;
  logic [CNT_W-1:0] tari, rtcal, trcal, delim;
  logic             tx, busy, done, err;

  always #5 clk = ~clk;

  pie_tx_gen #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wr_stb(wr_stb), .wr_data(wr_data), .start(start),
    .frame_len(frame_len), .preamble_sel(preamble_sel), .crc_sel(crc_sel),
    .tari(tari), .rtcal(rtcal), .trcal(trcal), .delim(delim),
    .tx(tx), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {logic tx; logic busy; logic done;} exp_t;
  exp_t       expq[$];
  exp_t       cur_e;
  bit         capq[$];
  bit         dec[$];
  bit         wave[$];
  bit         bits[$];
  logic [7:0] bytes_q[$];
  int         checks = 0;
  int         failures = 0;
  bit         chk_on = 0;
  bit         cap_on = 0;
  int         ncyc;
  int         nfr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

`ifdef PIE_TX_CRC_EN
  function automatic logic [4:0] crc5_of(input bit q[$]);
    logic [4:0] c = 5'b01001;
    foreach (q[i]) c = (c[4] ^ q[i]) ? ({c[3:0], 1'b0} ^ 5'b01001) : {c[3:0], 1'b0};
    return c;
  endfunction

  function automatic logic [15:0] crc16_of(input bit q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) c = (c[15] ^ q[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction
`endif

  // Payload bits in write order, MSB first, plus the CRC trailer when it is compiled in.
  task automatic make_bits(input int len, input logic [1:0] cs);
    logic [15:0] c;
    bits.delete();
    for (int i = 0; i < len; i++) bits.push_back(bytes_q[i/8][7 - (i % 8)]);
    c = '0;
`ifdef PIE_TX_CRC_EN
    if (cs == 2'b01) begin
      c = {11'd0, crc5_of(bits)};
      for (int i = 4; i >= 0; i--) bits.push_back(c[i]);
    end else if (cs == 2'b10) begin
      c = ~crc16_of(bits);
      for (int i = 15; i >= 0; i--) bits.push_back(c[i]);
    end
`else
    if (cs == 2'b11) c = 16'h0;
`endif
  endtask

  task automatic seg(input bit lvl, input int n);
    repeat (n) wave.push_back(lvl);
  endtask

  task automatic build(input int dl, input int t, input int rt, input int tc, input bit pre);
    int tt;
    tt = (t == 0) ? 1 : t;
    wave.delete();
    seg(0, dl);
    seg(1, tt); seg(0, tt); seg(1, rt); seg(0, tt);
    if (pre) begin seg(1, tc); seg(0, tt); end
    foreach (bits[i]) begin seg(1, bits[i] ? 3 * tt : tt); seg(0, tt); end
  endtask

  // Per-cycle compare: follow the expected queue during a frame, otherwise the line must be idle.
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      if (expq.size() > 0) begin
        cur_e = expq.pop_front();
        check("cyc_tx", tx, cur_e.tx);
        check("cyc_busy", busy, cur_e.busy);
        check("cyc_done", done, cur_e.done);
      end else begin
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
      end
    end
    if (cap_on && busy === 1'b1 && done === 1'b0) capq.push_back(tx);
  end

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    wr_stb = 1; wr_data = b;
    if (bytes_q.size() < MAX_BITS / 8) bytes_q.push_back(b);
    @(negedge clk);
    wr_stb = 0;
  endtask

  task automatic launch(input int len, input int dl, input int t, input int rt, input int tc,
                        input bit pre, input logic [1:0] cs);
    make_bits(len, cs);
    build(dl, t, rt, tc, pre);
    @(negedge clk);
    frame_len = CNT_W'(len); delim = CNT_W'(dl); tari = CNT_W'(t);
    rtcal = CNT_W'(rt); trcal = CNT_W'(tc); preamble_sel = pre; crc_sel = cs; start = 1;
    foreach (wave[i]) expq.push_back({wave[i], 1'b1, 1'b0});
    expq.push_back(3'b111);
    expq.push_back(3'b100);
    capq.delete();
    cap_on = 1;
    @(negedge clk);
    start = 0;
    bytes_q.delete();
  endtask

  task automatic wait_q(input int budget);
    int n;
    n = 0;
    while (expq.size() > 0 && n < budget) begin @(negedge clk); n++; end
    check("queue_drain", expq.size(), 0);
    expq.delete();
    cap_on = 0;
  endtask

  task automatic wait_frame(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk); #2; n++;
      if (done === 1'b1) break;
    end
    wait_q(8);
  endtask

  task automatic decode(input int skip, input int t);
    int i, hi;
    i = skip;
    dec.delete();
    while (i < capq.size()) begin
      hi = 0;
      while (i < capq.size() && capq[i]) begin hi++; i++; end
      while (i < capq.size() && !capq[i]) i++;
      if (hi == 0) break;
      dec.push_back(hi > 2 * t);
    end
  endtask

  function automatic logic [31:0] dec_val();
    logic [31:0] v = '0;
    foreach (dec[i]) v = {v[30:0], dec[i]};
    return v;
  endfunction

  task automatic reject(input int len);
    @(negedge clk);
    frame_len = CNT_W'(len); start = 1;
    @(negedge clk);
    start = 0;
    check("rej_err", err, 1);
    check("rej_busy", busy, 0);
    check("rej_tx", tx, 1);
  endtask

  initial begin
    reset = 1; wr_stb = 0; wr_data = 0; start = 0; frame_len = 0; preamble_sel = 0;
    crc_sel = 0; tari = 0; rtcal = 0; trcal = 0; delim = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1); check("rst_busy", busy, 0);
    check("rst_done", done, 0); check("rst_err", err, 0);
    reset = 0; chk_on = 1;

    // Full preamble: 8 + 48 + 40 cycles.
    wr(8'h80);
    launch(4, 8, 4, 12, 20, 1, 2'b00);
    check("t1_model_len", wave.size(), 96);
    wait_frame(400, ncyc);
    check("t1_done_cyc", ncyc, 96);
    decode(8 + 48, 4);
    check("t1_nbits", dec.size(), 4);
    check("t1_bits", dec_val(), 32'b1000);

    // Frame-sync: 8 + 24 + 40 cycles.
    wr(8'h80);
    launch(4, 8, 4, 12, 20, 0, 2'b00);
    check("t2_model_len", wave.size(), 72);
    wait_frame(400, ncyc);
    check("t2_done_cyc", ncyc, 72);
    decode(8 + 24, 4);
    check("t2_bits", dec_val(), 32'b1000);

    wr(8'h12); wr(8'h34);
    launch(16, 5, 3, 9, 15, 1, 2'b10);
    wait_frame(2000, ncyc);
    decode(5 + 3 * 3 + 9 + 15 + 3, 3);
`ifdef PIE_TX_CRC_EN
    check("t3_nbits", dec.size(), 32);
    check("t3_residue", {16'd0, crc16_of(dec)}, 32'h1D0F);
    check("t3_payload", dec_val() >> 16, 32'h1234);
`else
    check("t3_nbits", dec.size(), 16);
    check("t3_payload", dec_val(), 32'h1234);
`endif

    wr(8'h88); wr(8'h00); wr(8'h00);
    launch(17, 5, 3, 9, 15, 0, 2'b01);
    wait_frame(2000, ncyc);
    decode(5 + 3 * 3 + 9, 3);
`ifdef PIE_TX_CRC_EN
    check("t4_nbits", dec.size(), 22);
    check("t4_residue", {27'd0, crc5_of(dec)}, 32'h0);
    check("t4_payload", dec_val() >> 5, 32'h11000);
`else
    check("t4_nbits", dec.size(), 17);
    check("t4_payload", dec_val(), 32'h11000);
`endif

    // tari of 0 behaves as 1.
    wr(8'hA5);
    launch(8, 3, 0, 3, 5, 0, 2'b11);
    wait_frame(400, ncyc);
    decode(3 + 1 + 1 + 3 + 1, 1);
    check("t5_bits", dec_val(), 32'hA5);
    check("t5_done_cyc", ncyc, 9 + 4 * 4 + 2 * 4);

    // Start while busy and a start coinciding with done are both ignored.
    wr(8'h5A);
    launch(8, 4, 2, 6, 10, 1, 2'b00);
    nfr = wave.size();
    repeat (20) @(negedge clk);
    start = 1; frame_len = 3; tari = 7;
    @(negedge clk);
    start = 0;
    repeat (nfr + 1 - 22) @(negedge clk);
    check("t6_done_now", done, 1);
    start = 1; frame_len = 8;
    @(negedge clk);
    start = 0;
    wait_q(8);
    repeat (6) @(negedge clk);
    check("t6_err", err, 0);

    // Overflow: 65th byte dropped and err set; full 512-bit frame uses only the first 64.
    for (int i = 0; i < MAX_BITS / 8; i++) wr(8'((i * 37 + 11) % 256));
    check("t7_err_full", err, 0);
    wr(8'hFF);
    check("t7_err_ovf", err, 1);
    launch(MAX_BITS, 2, 1, 3, 5, 0, 2'b00);
    check("t7_err_clr", err, 0);
    wait_frame(5000, ncyc);
    check("t7_done_cyc", ncyc, wave.size());

    reject(0);
    repeat (3) @(negedge clk);
    check("t8_err_sticky", err, 1);
    reject(MAX_BITS + 1);

    // Reset in the middle of DATA.
    wr(8'hFF);
    launch(8, 2, 2, 4, 6, 1, 2'b00);
    check("t9_err_clr", err, 0);
    repeat (24) @(negedge clk);
    check("t9_busy_mid", busy, 1);
    expq.delete(); cap_on = 0; reset = 1;
    @(posedge clk); #2;
    check("t9_tx", tx, 1); check("t9_busy", busy, 0);
    check("t9_done", done, 0); check("t9_err", err, 0);
    @(negedge clk);
    reset = 0;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/pie_tx_gen.md
PIE_TX_GEN -- requirements
Module: pie_tx_gen

Interface
REQ-001 Parameter MAX_BITS, default 512: frame buffer depth in bits; multiple of 8.
REQ-002 Parameter CNT_W, default 16: width of timing and length counters.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port wr_stb, input, 1: one-cycle byte-write strobe.
REQ-006 Port wr_data, input, 8: byte written on wr_stb.
REQ-007 Port start, input, 1: one-cycle frame launch request.
REQ-008 Port frame_len, input, CNT_W: payload length in bits.
REQ-009 Port preamble_sel, input, 1: 1 = full preamble; 0 = frame-sync.
REQ-010 Port crc_sel, input, 2: 00 none, 01 CRC5, 10 CRC16, 11 treated as none.
REQ-011 Ports tari, rtcal, trcal, delim, input, CNT_W each: symbol timings in clk cycles.
REQ-012 Port tx, output, 1: PIE line; idle high.
REQ-013 Port busy, output, 1: high from accepted start until done.
REQ-014 Port done, output, 1: one-cycle pulse when the frame completes.
REQ-015 Port err, output, 1: sticky overflow/reject flag; cleared by an accepted start.

Function
REQ-016 States shall be IDLE, DELIM, SYNC, DATA, CRC, FINISH.
REQ-017 IDLE, wr_stb: shall append the byte to the buffer; bits are later sent in write order, MSB of each byte first.
REQ-018 A write beyond MAX_BITS/8 bytes shall be dropped and shall set err; wr_stb while busy shall be ignored and shall set err.
REQ-019 IDLE, start with 1 <= frame_len <= MAX_BITS: shall latch all timing inputs, crc_sel and preamble_sel, assert busy next cycle, and enter DELIM.
REQ-020 start with frame_len = 0 or > MAX_BITS shall be rejected, with err set and busy low; start while busy shall be ignored.
REQ-021 A latched tari of 0 shall be used as 1.
REQ-022 DELIM: tx low for delim cycles, beginning the cycle after start is accepted.
REQ-023 SYNC: tx high tari, low tari, high rtcal, low tari.
REQ-024 SYNC, preamble_sel = 1 only: additionally tx high trcal, low tari.
REQ-025 DATA symbols: data-0 = tari high then tari low; data-1 = 3*tari high then tari low.
REQ-026 CRC shall be computed over exactly the frame_len payload bits as sent.
REQ-027 CRC5: polynomial x^5+x^3+1, preset 01001, sent MSB first, not inverted.
REQ-028 CRC16: CCITT x^16+x^12+x^5+1, preset FFFF, sent ones-complemented, MSB first.
REQ-029 After the last symbol, tx shall return high.
REQ-030 done pulses in that same cycle; busy drops the next cycle.
REQ-031 The buffer write pointer shall clear at done so the next frame starts empty.
REQ-032 Counter arithmetic shall be CNT_W wide; a count that reaches its target wraps to 1, never 0.
REQ-033 A start that coincides with done shall be ignored.

Reset
REQ-034 reset high shall set tx=1, busy=0, done=0, err=0, state=IDLE, write pointer=0, and all counters 0, regardless of the current state.
REQ-035 Reset mid-frame shall abort the frame, with tx high the following cycle and no done pulse.

Configuration
REQ-036 Macro PIE_TX_CRC_EN shall control CRC support.
REQ-037 With PIE_TX_CRC_EN defined, crc_sel shall be honoured and the CRC state and generators shall exist.
REQ-038 Without PIE_TX_CRC_EN, crc_sel shall be ignored, no CRC shall be appended, no CRC logic shall be instantiated, and the CRC state shall be unreachable.

Verification
REQ-039 Write 0x80, frame_len=4, tari=4, rtcal=12, trcal=20, delim=8, preamble_sel=1, crc_sel=00 -> tx low 8 cycles after start, sync 48 cycles, data 1000 taking 40 cycles, done exactly 96 cycles after start accepted.
REQ-040 Same setup, preamble_sel=0 -> sync 24 cycles, done 72 cycles after start.
REQ-041 Write 0x12,0x34, frame_len=16, crc_sel=10 -> 32 decoded bits; bench CRC16 (preset FFFF) over all 32 bits gives residue 0x1D0F.
REQ-042 Write 0x88,0x00,0x00, frame_len=17, crc_sel=01 -> 22 decoded bits; bench CRC5 (preset 01001) over all 22 bits gives residue 00000.
REQ-043 Write MAX_BITS/8+1 bytes -> err=1, last byte dropped. Separately: start with frame_len=0 -> err=1, busy stays 0, tx stays high.
REQ-044 Assert reset during the DATA state -> tx=1 and busy=0 on the next cycle, no done pulse. Separately: start during busy -> no effect on the tx waveform.
